// File: rtl/cpu_defs.sv
// Shared CPU decode types: operation codes, decoded instruction, issue-queue entry,
// and operation-class helpers.
package cpu_defs;

  typedef logic [31:0] uint32_t;

  typedef enum logic [5:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_OR, OP_AND, OP_SLL,
    OP_LW, OP_SW, OP_LB, OP_SB,
    OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
    OP_MUL, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_SYSCALL, OP_BREAK, OP_ERET, OP_MTC0, OP_INVALID
  } oper_t;

  typedef struct packed {
    oper_t      op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       is_load;
    logic       is_store;
    logic       is_controlflow;
    logic       is_priv;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t instr;
    uint32_t        pc;
  } queue_entry_t;

  // Ops that share the single HI/LO multiply-divide unit.
  function automatic logic is_muldiv(oper_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
      OP_MUL, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  // Ops that must issue alone: privileged or raising an exception at execute.
  function automatic logic is_serial(decoded_instr_t i);
    return i.is_priv || (i.op == OP_SYSCALL) || (i.op == OP_BREAK) || (i.op == OP_INVALID);
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Combinational dual-issue decision for the two oldest queue entries.
module issue_pair_check
  import cpu_defs::*;
#(
  parameter int CNT_W = 4
) (
  input  decoded_instr_t   head_instr,
  input  decoded_instr_t   next_instr,
  input  logic [CNT_W-1:0] count,
  output logic [1:0]       pair_valid
);

  logic has1;
  logic has2;
  logic raw;
  logic mem_conflict;
  logic md_conflict;
  logic serial;
  logic v0;

  assign has1 = (count >= CNT_W'(1));
  assign has2 = (count >= CNT_W'(2));

  assign raw = (head_instr.rd != 5'd0) &&
               ((head_instr.rd == next_instr.rs1) || (head_instr.rd == next_instr.rs2));
  assign mem_conflict = (head_instr.is_load || head_instr.is_store) &&
                        (next_instr.is_load || next_instr.is_store);
  assign md_conflict  = is_muldiv(head_instr.op) && is_muldiv(next_instr.op);
  assign serial       = is_serial(head_instr) || is_serial(next_instr);

  // A branch is held until its delay slot is queued behind it.
  assign v0 = has1 && !(head_instr.is_controlflow && !has2);

  always_comb begin
    pair_valid = 2'b00;
    pair_valid[0] = v0;
    if (head_instr.is_controlflow) begin
      // Branch and delay slot always leave together; hazards inside the pair are resolved downstream.
      pair_valid[1] = v0;
    end else begin
      pair_valid[1] = v0 && has2 && !raw && !mem_conflict && !md_conflict &&
                      !serial && !next_instr.is_controlflow;
    end
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Dual-push circular instruction queue with a dual-issue pairing scheduler
// between decode and register-read.
module decode_issue_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [1:0]           in_valid,
  input  decoded_instr_t [1:0] in_instr,
  input  uint32_t [1:0]        in_pc,
  output logic                 in_ready,
  output logic [1:0]           out_valid,
  output decoded_instr_t [1:0] out_instr,
  output uint32_t [1:0]        out_pc,
  input  logic                 issue_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  queue_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] head_1;
  logic [PTR_W-1:0] tail_1;
  logic             push_ok;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] issue_n;

  assign head_1 = head + PTR_W'(1);
  assign tail_1 = tail + PTR_W'(1);

  // Ready depends on the registered count only, so a same-cycle issue cannot reopen it.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));
  assign push_ok  = in_valid[0] && in_ready;
  assign push_n   = push_ok ? (in_valid[1] ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign issue_n  = issue_ready ? (CNT_W'(out_valid[0]) + CNT_W'(out_valid[1])) : '0;

  assign out_instr[0] = mem[head].instr;
  assign out_instr[1] = mem[head_1].instr;
  assign out_pc[0]    = mem[head].pc;
  assign out_pc[1]    = mem[head_1].pc;

  issue_pair_check #(
    .CNT_W(CNT_W)
  ) u_pair (
    .head_instr(mem[head].instr),
    .next_instr(mem[head_1].instr),
    .count     (count),
    .pair_valid(out_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(issue_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + push_n - issue_n;
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[tail] <= '{instr: in_instr[0], pc: in_pc[0]};
      if (in_valid[1]) begin
        mem[tail_1] <= '{instr: in_instr[1], pc: in_pc[1]};
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: pairing rules, branch delay slots, full/wrap, flush, reset.
module tb_decode_issue_queue;
  import cpu_defs::*;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic [1:0]           in_valid;
  decoded_instr_t [1:0] in_instr;
  uint32_t [1:0]        in_pc;
  logic                 in_ready;
  logic [1:0]           out_valid;
  decoded_instr_t [1:0] out_instr;
  uint32_t [1:0]        out_pc;
  logic                 issue_ready;

  int checks;
  int failures;

  decode_issue_queue #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .issue_ready(issue_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input oper_t op, input int rd, input int rs1, input int rs2);
    decoded_instr_t d;
    d = '0;
    d.op  = op;
    d.rd  = 5'(rd);
    d.rs1 = 5'(rs1);
    d.rs2 = 5'(rs2);
    d.is_load        = (op == OP_LW);
    d.is_store       = (op == OP_SW);
    d.is_controlflow = (op == OP_BEQ) || (op == OP_JAL);
    d.is_priv        = (op == OP_ERET);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [1:0] v, input decoded_instr_t a, input uint32_t pa,
                          input decoded_instr_t b, input uint32_t pb);
    in_valid    = v;
    in_instr[0] = a;
    in_pc[0]    = pa;
    in_instr[1] = b;
    in_pc[1]    = pb;
  endtask

  task automatic no_push();
    in_valid = 2'b00;
  endtask

  task automatic check_state(input string tag, input logic [1:0] ov, input int cnt, input logic rdy);
    check({tag, "_ov"},  32'(out_valid),  32'(ov));
    check({tag, "_cnt"}, 32'(dut.count),  32'(cnt));
    check({tag, "_rdy"}, 32'(in_ready),   32'(rdy));
  endtask

  // Push a pair with issue held, expect single issue of each in order.
  task automatic serial_pair(input string tag, input decoded_instr_t a, input decoded_instr_t b,
                             input uint32_t pa);
    issue_ready = 1'b0;
    set_push(2'b11, a, pa, b, pa + 32'd4);
    tick();
    no_push();
    check({tag, "_first_ov"}, 32'(out_valid), 32'(2'b01));
    check({tag, "_first_pc"}, out_pc[0], pa);
    issue_ready = 1'b1;
    tick();
    check({tag, "_second_ov"}, 32'(out_valid), 32'(2'b01));
    check({tag, "_second_pc"}, out_pc[0], pa + 32'd4);
    tick();
    check_state({tag, "_empty"}, 2'b00, 0, 1'b1);
  endtask

  task automatic pair_issue(input string tag, input decoded_instr_t a, input decoded_instr_t b,
                            input uint32_t pa);
    issue_ready = 1'b0;
    set_push(2'b11, a, pa, b, pa + 32'd4);
    tick();
    no_push();
    check({tag, "_ov"},  32'(out_valid), 32'(2'b11));
    check({tag, "_pc1"}, out_pc[1], pa + 32'd4);
    issue_ready = 1'b1;
    tick();
    check_state({tag, "_empty"}, 2'b00, 0, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b0;
    in_valid = 2'b00;
    in_instr = '0;
    in_pc = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check_state("reset", 2'b00, 0, 1'b1);

    // Independent ALU pair
    pair_issue("indep", mk(OP_ADDU, 3, 1, 2), mk(OP_OR, 5, 4, 6), 32'h100);
    // Writes to r0 never create a RAW hazard
    pair_issue("r0dst", mk(OP_ADDU, 0, 1, 2), mk(OP_SUBU, 7, 0, 1), 32'h180);

    serial_pair("raw",     mk(OP_ADDU, 3, 1, 2),  mk(OP_SUBU, 7, 3, 1), 32'h200);
    serial_pair("ldst",    mk(OP_LW, 8, 29, 0),   mk(OP_SW, 0, 29, 9),  32'h240);
    serial_pair("muldiv",  mk(OP_MULT, 0, 4, 5),  mk(OP_MFLO, 6, 0, 0), 32'h280);
    serial_pair("syscall", mk(OP_SYSCALL, 0, 0, 0), mk(OP_ADDU, 3, 1, 2), 32'h2c0);

    // Branch waits for delay slot
    issue_ready = 1'b1;
    set_push(2'b01, mk(OP_BEQ, 0, 1, 2), 32'h300, '0, 32'h0);
    tick();
    check_state("br_alone", 2'b00, 1, 1'b1);
    issue_ready = 1'b0;
    set_push(2'b01, mk(OP_LW, 4, 29, 0), 32'h304, '0, 32'h0);
    tick();
    no_push();
    check("br_slot_ov",  32'(out_valid), 32'(2'b11));
    check("br_slot_op0", 32'(out_instr[0].op), 32'(OP_BEQ));
    check("br_slot_op1", 32'(out_instr[1].op), 32'(OP_LW));
    check("br_slot_pc1", out_pc[1], 32'h304);
    issue_ready = 1'b1;
    tick();
    check_state("br_drain", 2'b00, 0, 1'b1);

    // Delay slot pairing bypasses RAW and serialising rules
    pair_issue("jal_raw", mk(OP_JAL, 31, 0, 0), mk(OP_ADDU, 2, 31, 0), 32'h340);
    pair_issue("br_sys",  mk(OP_BEQ, 0, 1, 2),  mk(OP_SYSCALL, 0, 0, 0), 32'h380);

    // Fill to full with issue held
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h400 + 32'(8 * i),
               mk(OP_OR, 4, 5, 6), 32'h404 + 32'(8 * i));
      tick();
      check("fill_cnt", 32'(dut.count), 32'(2 * (i + 1)));
      check("fill_rdy", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h500, mk(OP_OR, 4, 5, 6), 32'h504);
    tick();
    check("full_drop_cnt", 32'(dut.count), 32'd8);
    no_push();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_ov",  32'(out_valid), 32'(2'b11));
      check("drain_pc0", out_pc[0], 32'h400 + 32'(8 * i));
      check("drain_pc1", out_pc[1], 32'h404 + 32'(8 * i));
      check("drain_rdy", 32'(in_ready), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    check_state("drained", 2'b00, 0, 1'b1);

    // Ten more entries through wrapped pointers with concurrent push and issue
    issue_ready = 1'b0;
    set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h600, mk(OP_OR, 4, 5, 6), 32'h604);
    tick();
    issue_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h600 + 32'(8 * j),
               mk(OP_OR, 4, 5, 6), 32'h604 + 32'(8 * j));
      tick();
      check("wrap_pc0", out_pc[0], 32'h600 + 32'(8 * j));
      check("wrap_pc1", out_pc[1], 32'h604 + 32'(8 * j));
      check("wrap_cnt", 32'(dut.count), 32'd2);
    end
    no_push();
    tick();
    check_state("wrap_done", 2'b00, 0, 1'b1);

    // Flush with count 5 and a same-cycle push
    issue_ready = 1'b0;
    set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h700, mk(OP_OR, 4, 5, 6), 32'h704);
    tick();
    set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h708, mk(OP_OR, 4, 5, 6), 32'h70c);
    tick();
    set_push(2'b01, mk(OP_ADDU, 1, 2, 3), 32'h710, '0, 32'h0);
    tick();
    check("pre_flush_cnt", 32'(dut.count), 32'd5);
    set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h714, mk(OP_OR, 4, 5, 6), 32'h718);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    no_push();
    check_state("flush", 2'b00, 0, 1'b1);
    set_push(2'b01, mk(OP_ADDU, 1, 2, 3), 32'h720, '0, 32'h0);
    tick();
    no_push();
    check("post_flush_ov", 32'(out_valid), 32'(2'b01));
    check("post_flush_pc", out_pc[0], 32'h720);

    // Reset mid-stream with a same-cycle push
    set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h800, mk(OP_OR, 4, 5, 6), 32'h804);
    tick();
    rst_n = 1'b0;
    set_push(2'b11, mk(OP_ADDU, 1, 2, 3), 32'h808, mk(OP_OR, 4, 5, 6), 32'h80c);
    tick();
    rst_n = 1'b1;
    no_push();
    check_state("midreset", 2'b00, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
